// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode encodings and a
// constant ceil-log2 helper for the modulo counter slice.
package counter_pkg;

    localparam bit CNT_DN    = 1'b0;
    localparam bit CNT_UP    = 1'b1;
    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Never returns 0 so it can size a vector directly.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one TICK every PRESCALE enabled cycles;
// the phase holds while EN is low and restarts on SYNC_CLR.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic SYNC_CLR,
    output logic TICK
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic unused_in;
            assign unused_in = ^{CLK, RST, SYNC_CLR};
            assign TICK = EN;
        end else begin : g_div
            localparam int PW = clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            localparam logic [PW-1:0] ONE  = PW'(1);

            logic [PW-1:0] cnt;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt <= '0;
                end else if (SYNC_CLR) begin
                    cnt <= '0;
                end else if (EN) begin
                    cnt <= (cnt == LAST) ? '0 : cnt + ONE;
                end
            end

            assign TICK = EN && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter with
// clear, clamped load, prescaled stepping and terminal-count pulse.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15,
    parameter int RST_VAL  = MAX_VAL,
    parameter int PRESCALE = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] OUT,
    output logic             TC,
    output logic             ZERO
);

    generate
        if (MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
            $error("MAX_VAL does not fit in WIDTH bits");
        end
        if (RST_VAL > MAX_VAL || RST_VAL < 0) begin : g_bad_rst
            $error("RST_VAL outside 0..MAX_VAL");
        end
        if (PRESCALE < 1) begin : g_bad_ps
            $error("PRESCALE must be at least 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic             tick;
    logic             at_end;
    logic             tc_d;
    logic [WIDTH-1:0] load_clamp;
    logic [WIDTH-1:0] out_d;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .SYNC_CLR (CLR | LOAD),
        .TICK     (tick)
    );

    assign load_clamp = (LOAD_VAL > MAXV) ? MAXV : LOAD_VAL;

    // Boundary is tested before stepping, so no WIDTH overflow.
    assign at_end = (UP == CNT_UP) ? (OUT == MAXV)
                                   : (OUT == '0);

    always_comb begin
        out_d = OUT;
        tc_d  = 1'b0;
        if (CLR) begin
            out_d = RSTV;
        end else if (LOAD) begin
            out_d = load_clamp;
        end else if (tick) begin
            tc_d = at_end;
            if (!at_end) begin
                out_d = (UP == CNT_UP) ? OUT + ONE
                                       : OUT - ONE;
            end else if (SATURATE != MODE_SAT) begin
                out_d = (UP == CNT_UP) ? '0 : MAXV;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT <= RSTV;
            TC  <= 1'b0;
        end else begin
            OUT <= out_d;
            TC  <= tc_d;
        end
    end

    assign ZERO = (OUT == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: four configurations on shared stimulus,
// directed tables/sequences plus random run against a model.
module tb_updown_mod_counter;

    localparam int N = 4;
    localparam int MX [N] = '{15, 9, 15, 15};
    localparam int RV [N] = '{15, 0, 15, 0};
    localparam int PS [N] = '{1, 1, 1, 3};
    localparam bit SA [N] = '{0, 0, 1, 0};

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       UP;
    logic       CLR;
    logic       LOAD;
    logic [3:0] LOAD_VAL;
    logic [3:0] out_q  [N];
    logic       tc_q   [N];
    logic       zero_q [N];

    int n_chk;
    int n_fail;
    int m_out [N];
    int m_ps  [N];
    bit m_tc  [N];

    typedef struct {
        bit       en;
        bit       up;
        bit       clr;
        bit       load;
        bit [3:0] lv;
        int       eo;
        bit       et;
    } vec_t;

    vec_t tbl [20];

    updown_mod_counter u_d0 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP),
        .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .OUT(out_q[0]), .TC(tc_q[0]), .ZERO(zero_q[0])
    );

    updown_mod_counter #(
        .MAX_VAL(9), .RST_VAL(0)
    ) u_d1 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP),
        .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .OUT(out_q[1]), .TC(tc_q[1]), .ZERO(zero_q[1])
    );

    updown_mod_counter #(
        .SATURATE(1'b1)
    ) u_d2 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP),
        .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .OUT(out_q[2]), .TC(tc_q[2]), .ZERO(zero_q[2])
    );

    updown_mod_counter #(
        .RST_VAL(0), .PRESCALE(3)
    ) u_d3 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP),
        .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .OUT(out_q[3]), .TC(tc_q[3]), .ZERO(zero_q[3])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i] = RV[i];
            m_tc[i]  = 1'b0;
            m_ps[i]  = 0;
        end
    endtask

    // Advances the model by one edge from the current inputs.
    task automatic model_edge();
        bit tk;
        bit edge_hit;
        for (int i = 0; i < N; i++) begin
            m_tc[i] = 1'b0;
            if (CLR) begin
                m_out[i] = RV[i];
                m_ps[i]  = 0;
            end else if (LOAD) begin
                m_out[i] = (int'(LOAD_VAL) > MX[i]) ? MX[i] : int'(LOAD_VAL);
                m_ps[i]  = 0;
            end else if (EN) begin
                tk = (m_ps[i] == PS[i] - 1);
                m_ps[i] = (m_ps[i] + 1) % PS[i];
                if (tk) begin
                    edge_hit = UP ? (m_out[i] == MX[i]) : (m_out[i] == 0);
                    m_tc[i] = edge_hit;
                    if (!(edge_hit && SA[i])) begin
                        if (UP)
                            m_out[i] = (m_out[i] + 1) % (MX[i] + 1);
                        else
                            m_out[i] = (m_out[i] + MX[i]) % (MX[i] + 1);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("out%0d", i), int'(out_q[i]), m_out[i]);
            chk($sformatf("tc%0d", i), int'(tc_q[i]), int'(m_tc[i]));
            chk($sformatf("zero%0d", i), int'(zero_q[i]),
                (m_out[i] == 0) ? 1 : 0);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic drive(input bit en, input bit up, input bit clr,
                         input bit load, input bit [3:0] lv);
        EN = en;
        UP = up;
        CLR = clr;
        LOAD = load;
        LOAD_VAL = lv;
    endtask

    // Reset pulse placed between edges; checked while RST is high.
    task automatic pulse_rst();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_async_out0", int'(out_q[0]), 15);
        chk("rst_async_tc0", int'(tc_q[0]), 0);
        RST = 1'b0;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        RST = 1'b1;
        drive(0, 0, 0, 0, 4'd0);
        model_reset();

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1, 0, 0, 0, 4'd0, (i < 15) ? 14 - i : 15, i == 15};
        end
        tbl[16] = '{1, 0, 0, 1, 4'd5, 5, 0};
        tbl[17] = '{1, 1, 0, 0, 4'd0, 6, 0};
        tbl[18] = '{1, 1, 1, 1, 4'd3, 15, 0};
        tbl[19] = '{0, 1, 0, 0, 4'd0, 15, 0};

        #2;
        check_all();
        chk("reset_out0", int'(out_q[0]), 15);
        chk("reset_zero1", int'(zero_q[1]), 1);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].en, tbl[i].up, tbl[i].clr,
                  tbl[i].load, tbl[i].lv);
            cycle();
            chk($sformatf("tbl%0d_out", i), int'(out_q[0]), tbl[i].eo);
            chk($sformatf("tbl%0d_tc", i), int'(tc_q[0]), int'(tbl[i].et));
        end

        pulse_rst();
        drive(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 8; i++) cycle();
        chk("cnt_to_7", int'(out_q[0]), 7);
        pulse_rst();
        chk("after_rst_15", int'(out_q[0]), 15);
        cycle();
        chk("resume_14", int'(out_q[0]), 14);

        pulse_rst();
        drive(1, 1, 0, 0, 4'd0);
        for (int i = 1; i <= 10; i++) begin
            cycle();
            chk($sformatf("mod10_out_%0d", i), int'(out_q[1]), i % 10);
            chk($sformatf("mod10_tc_%0d", i), int'(tc_q[1]),
                (i == 10) ? 1 : 0);
        end
        drive(1, 1, 0, 1, 4'd12);
        cycle();
        chk("clamp_d1", int'(out_q[1]), 9);
        chk("noclamp_d0", int'(out_q[0]), 12);

        drive(1, 0, 0, 1, 4'd2);
        cycle();
        chk("sat_load", int'(out_q[2]), 2);
        drive(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("sat_out_%0d", i), int'(out_q[2]),
                (i == 0) ? 1 : 0);
            chk($sformatf("sat_tc_%0d", i), int'(tc_q[2]),
                (i >= 2) ? 1 : 0);
        end
        drive(1, 1, 0, 0, 4'd0);
        cycle();
        chk("sat_up", int'(out_q[2]), 1);
        chk("sat_up_tc", int'(tc_q[2]), 0);

        pulse_rst();
        drive(1, 1, 0, 0, 4'd0);
        for (int i = 1; i <= 7; i++) begin
            cycle();
            chk($sformatf("ps_out_%0d", i), int'(out_q[3]), i / 3);
        end
        drive(0, 1, 0, 0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("ps_freeze", int'(out_q[3]), 2);
        end
        drive(1, 1, 0, 0, 4'd0);
        cycle();
        chk("ps_phase_kept", int'(out_q[3]), 2);
        cycle();
        chk("ps_step3", int'(out_q[3]), 3);
        drive(1, 1, 0, 1, 4'd5);
        cycle();
        chk("ps_load", int'(out_q[3]), 5);
        drive(1, 1, 0, 0, 4'd0);
        cycle();
        cycle();
        chk("ps_load_phase0", int'(out_q[3]), 5);
        cycle();
        chk("ps_load_step", int'(out_q[3]), 6);
        drive(1, 1, 1, 1, 4'd7);
        cycle();
        chk("clr_wins_d3", int'(out_q[3]), 0);
        chk("clr_wins_d0", int'(out_q[0]), 15);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 19) == 0,
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0)
                pulse_rst();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
